// File: rtl/fixed_point_abs_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// abs_arb_pkg
// Shared definitions for the fixed-point ABS arbiter slice:
//   state_t    - FSM state encoding (IDLE / ISSUE / WAIT / RESP)
//   id_width() - width of an encoded requester id for a given requester count
//   TMO_CNT_W  - width of the WAIT-state timeout counter (ABS_ARB_TIMEOUT_EN)
// -----------------------------------------------------------------------------
package abs_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   // Wide enough for any practical TIMEOUT_CYCLES value.
   localparam int TMO_CNT_W = 16;

   function automatic int id_width(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

endpackage

// File: rtl/fixed_point_abs_arbiter_if.sv
// -----------------------------------------------------------------------------
// fixed_point_abs_arbiter_if
// Bundles the requester-side and shared-unit-side signals of the arbiter.
//   REQ_VALID/REQ_VALUE/REQ_READY       - request handshake, NUM_REQ lanes
//   RSP_VALID/RSP_VALUE/RSP_ERR         - one-hot response pulse + result
//   UNIT_VALUE_OUT/UNIT_VALID_OUT       - operand issued to the shared unit
//   UNIT_VALUE_IN/UNIT_VALID_IN         - result returned by the shared unit
// Modports:
//   slave  - the arbiter itself
//   master - the surrounding environment (requesters + shared unit)
// -----------------------------------------------------------------------------
interface fixed_point_abs_arbiter_if #(
   parameter int WIDTH   = 8,
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]       REQ_VALID;
   logic [NUM_REQ*WIDTH-1:0] REQ_VALUE;
   logic [NUM_REQ-1:0]       REQ_READY;
   logic [NUM_REQ-1:0]       RSP_VALID;
   logic [WIDTH-1:0]         RSP_VALUE;
   logic                     RSP_ERR;
   logic [WIDTH-1:0]         UNIT_VALUE_OUT;
   logic                     UNIT_VALID_OUT;
   logic [WIDTH-1:0]         UNIT_VALUE_IN;
   logic                     UNIT_VALID_IN;

   modport slave (
      input  REQ_VALID, REQ_VALUE, UNIT_VALUE_IN, UNIT_VALID_IN,
      output REQ_READY, RSP_VALID, RSP_VALUE, RSP_ERR,
             UNIT_VALUE_OUT, UNIT_VALID_OUT
   );

   modport master (
      output REQ_VALID, REQ_VALUE, UNIT_VALUE_IN, UNIT_VALID_IN,
      input  REQ_READY, RSP_VALID, RSP_VALUE, RSP_ERR,
             UNIT_VALUE_OUT, UNIT_VALID_OUT
   );
endinterface

// File: rtl/fixed_point_abs_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. The winner is the first set request bit
// strictly after i_ptr, wrapping around to bit 0. The pointer register lives
// in the parent.
//   i_req   [NUM_REQ-1:0] - request vector
//   i_ptr   [ID_W-1:0]    - id of the previous winner
//   o_grant [NUM_REQ-1:0] - one-hot grant (all zero when no request)
//   o_id    [ID_W-1:0]    - encoded id of the granted requester
// -----------------------------------------------------------------------------
module rr_arbiter
   import abs_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = id_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [ID_W-1:0]    i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [ID_W-1:0]    o_id
);

   logic [NUM_REQ-1:0] w_above;
   logic [NUM_REQ-1:0] w_hi_req;
   logic [NUM_REQ-1:0] w_pick;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
      w_above = '0;
      o_id    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_above[i] = (i > int'(i_ptr));
      end
      // Requests above the pointer win; if there are none, wrap to the full set.
      w_hi_req = i_req & w_above;
      w_pick   = (|w_hi_req) ? w_hi_req : i_req;
      // Isolate the lowest set bit (x & -x).
      o_grant  = w_pick & (~w_pick + {{(NUM_REQ-1){1'b0}}, 1'b1});
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (o_grant[i]) o_id = ID_W'(i);
      end
   end

endmodule

// File: rtl/fixed_point_abs_arbiter.sv
// -----------------------------------------------------------------------------
// fixed_point_abs_arbiter
// Shares one fixed-point ABS unit between NUM_REQ requesters. Requesters are
// granted round-robin, one operation is in flight at a time, and the unit's
// result is returned bit-exact to the owner as a one-cycle RSP_VALID pulse.
// Ports:
//   CLK - clock
//   RST - asynchronous, active-high reset (must also reset the shared unit)
//   bus - fixed_point_abs_arbiter_if.slave (request, response, unit signals)
// Parameters: WIDTH, NUM_REQ, TIMEOUT_CYCLES.
// Configuration macro: ABS_ARB_TIMEOUT_EN - when defined, a WAIT-state
//   counter aborts the op after TIMEOUT_CYCLES cycles with RSP_ERR=1 and
//   RSP_VALUE=0. When undefined, RSP_ERR is tied 0 and WAIT holds forever.
// -----------------------------------------------------------------------------
module fixed_point_abs_arbiter
   import abs_arb_pkg::*;
#(
   parameter int WIDTH          = 8,
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 8
) (
   input  logic                         CLK,
   input  logic                         RST,
   fixed_point_abs_arbiter_if.slave     bus
);

   localparam int ID_W = id_width(NUM_REQ);

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_ISSUE = ISSUE;
   localparam logic [1:0] S_WAIT  = WAIT;
   localparam logic [1:0] S_RESP  = RESP;

   logic [1:0]         r_state;
   logic [ID_W-1:0]    r_ptr;
   logic [ID_W-1:0]    r_owner;
   logic [WIDTH-1:0]   r_operand;
   logic               r_unit_valid;
   logic [NUM_REQ-1:0] r_rsp_valid;
   logic [WIDTH-1:0]   r_rsp_value;

   logic [NUM_REQ-1:0] w_grant;
   logic [ID_W-1:0]    w_id;
   logic [WIDTH-1:0]   w_operand;
   logic [NUM_REQ-1:0] w_owner_oh;
   logic               w_xfer;

`ifdef ABS_ARB_TIMEOUT_EN
   localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);
   logic [TMO_CNT_W-1:0] r_tmo_cnt;
   logic                 r_rsp_err;
`endif

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_arbiter (
      .i_req   (bus.REQ_VALID),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_id    (w_id)
   );

   // Grant is only offered in IDLE, and is forced low while reset is held so
   // every output reads 0 during reset.
   assign bus.REQ_READY = (r_state == S_IDLE && !RST) ? w_grant : '0;
   assign w_xfer        = |bus.REQ_READY;
   assign w_owner_oh    = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_owner;

   always_comb begin
      w_operand = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_id == ID_W'(i)) w_operand = bus.REQ_VALUE[i*WIDTH +: WIDTH];
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values, matching the hardware.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state      <= S_IDLE;
         r_ptr        <= ID_W'(NUM_REQ - 1);   // requester 0 wins first
         r_owner      <= '0;
         r_operand    <= '0;
         r_unit_valid <= 1'b0;
         r_rsp_valid  <= '0;
         r_rsp_value  <= '0;
`ifdef ABS_ARB_TIMEOUT_EN
         r_tmo_cnt    <= '0;
         r_rsp_err    <= 1'b0;
`endif
      end else begin
         // Single-cycle pulses default low.
         r_unit_valid <= 1'b0;
         r_rsp_valid  <= '0;
`ifdef ABS_ARB_TIMEOUT_EN
         r_rsp_err    <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (w_xfer) begin
                  r_operand    <= w_operand;
                  r_owner      <= w_id;
                  r_ptr        <= w_id;
                  r_unit_valid <= 1'b1;     // operand valid during ISSUE
                  r_state      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_state <= S_WAIT;
`ifdef ABS_ARB_TIMEOUT_EN
               r_tmo_cnt <= '0;
`endif
            end
            S_WAIT: begin
               // Response registers are loaded here so the pulse lines up
               // with the RESP state; RSP_VALUE holds until the next load.
               if (bus.UNIT_VALID_IN) begin
                  r_rsp_valid <= w_owner_oh;
                  r_rsp_value <= bus.UNIT_VALUE_IN;
                  r_state     <= S_RESP;
               end
`ifdef ABS_ARB_TIMEOUT_EN
               else if (r_tmo_cnt == TMO_LAST) begin
                  r_rsp_valid <= w_owner_oh;
                  r_rsp_value <= '0;
                  r_rsp_err   <= 1'b1;
                  r_state     <= S_RESP;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + 1'b1;
               end
`endif
            end
            S_RESP:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.RSP_VALID      = r_rsp_valid;
   assign bus.RSP_VALUE      = r_rsp_value;
   assign bus.UNIT_VALUE_OUT = r_operand;
   assign bus.UNIT_VALID_OUT = r_unit_valid;
`ifdef ABS_ARB_TIMEOUT_EN
   assign bus.RSP_ERR        = r_rsp_err;
`else
   assign bus.RSP_ERR        = 1'b0;
`endif

endmodule

// File: tb/tb_fixed_point_abs_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fixed_point_abs_arbiter
// Self-checking bench for fixed_point_abs_arbiter: directed vector table,
// hand-written corner sequences (round-robin, stray unit results, reset in
// WAIT, timeout / indefinite WAIT) and a randomized phase checked against a
// cycle-level reference model. The shared ABS unit is a behavioural stub with
// latency 1 for non-negative and 2 for negative operands.
// -----------------------------------------------------------------------------
module tb_fixed_point_abs_arbiter;

   localparam int WIDTH   = 8;
   localparam int NUM_REQ = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fixed_point_abs_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus();

   fixed_point_abs_arbiter #(
      .WIDTH          (WIDTH),
      .NUM_REQ        (NUM_REQ),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*WIDTH-1:0] req_value;
   logic                     stray_v;
   logic [WIDTH-1:0]         stray_val;
   bit                       stub_en;

   logic             u_valid, u_pend;
   logic [WIDTH-1:0] u_val, u_pend_val;

   assign bus.REQ_VALID     = req_valid;
   assign bus.REQ_VALUE     = req_value;
   assign bus.UNIT_VALID_IN = u_valid | stray_v;
   assign bus.UNIT_VALUE_IN = stray_v ? stray_val : u_val;

   function automatic logic [WIDTH-1:0] abs_of(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? (~v + 1'b1) : v;
   endfunction

   // Shared ABS unit stub; reset together with the arbiter.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         u_valid <= 1'b0; u_pend <= 1'b0; u_val <= '0; u_pend_val <= '0;
      end else begin
         u_valid <= 1'b0;
         if (u_pend) begin
            u_valid <= 1'b1; u_val <= u_pend_val; u_pend <= 1'b0;
         end
         if (bus.UNIT_VALID_OUT && stub_en) begin
            if (bus.UNIT_VALUE_OUT[WIDTH-1]) begin
               u_pend <= 1'b1; u_pend_val <= abs_of(bus.UNIT_VALUE_OUT);
            end else begin
               u_valid <= 1'b1; u_val <= abs_of(bus.UNIT_VALUE_OUT);
            end
         end
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] v, input int ptr);
      for (int k = 1; k <= NUM_REQ; k++) begin
         int j;
         j = (ptr + k) % NUM_REQ;
         if (v[j]) return NUM_REQ'(1) << j;
      end
      return '0;
   endfunction

   task automatic wait_grant(input string tag, input int owner);
      int n;
      n = 0;
      @(negedge clk);
      while (bus.REQ_READY == '0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, " grant"}, 64'(bus.REQ_READY), 64'(NUM_REQ'(1) << owner));
   endtask

   // One full operation: present requests, expect a grant to 'owner', then
   // the issue cycle and a response pulse 'lat' cycles after the accept.
   task automatic do_op(input string tag, input logic [NUM_REQ-1:0] v,
                        input logic [NUM_REQ*WIDTH-1:0] vals, input int owner,
                        input logic [WIDTH-1:0] res, input int lat,
                        input bit keep, input bit stray_issue);
      @(posedge clk); #1;
      req_valid = v;
      req_value = vals;
      wait_grant(tag, owner);
      @(posedge clk); #1;
      if (stray_issue) begin
         stray_v = 1'b1; stray_val = 8'h55;
      end
      @(negedge clk);
      check({tag, " unit_valid"}, 64'(bus.UNIT_VALID_OUT), 64'd1);
      check({tag, " unit_value"}, 64'(bus.UNIT_VALUE_OUT), 64'(vals[owner*WIDTH +: WIDTH]));
      check({tag, " busy ready"}, 64'(bus.REQ_READY), 64'd0);
      @(posedge clk); #1;
      stray_v = 1'b0;
      for (int k = 2; k <= lat; k++) begin
         @(negedge clk);
         check({tag, " rsp_valid"}, 64'(bus.RSP_VALID),
               (k == lat) ? 64'(NUM_REQ'(1) << owner) : 64'd0);
      end
      check({tag, " rsp_value"}, 64'(bus.RSP_VALUE), 64'(res));
      check({tag, " rsp_err"},   64'(bus.RSP_ERR),   64'd0);
      check({tag, " rsp ready"}, 64'(bus.REQ_READY), 64'd0);
      if (!keep) begin
         @(posedge clk); #1;
         req_valid = '0;
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      req_valid = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   typedef struct {
      logic [NUM_REQ-1:0]       valid;
      logic [NUM_REQ*WIDTH-1:0] values;
      int                       owner;
      logic [WIDTH-1:0]         result;
      int                       lat;
   } vec_t;

   vec_t vecs[7];

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit                 m_busy;
      int                 m_owner, m_acc, m_rsp, m_ptr;
      logic [WIDTH-1:0]   m_op, m_res;
      logic [NUM_REQ-1:0] exp_ready;
      bit                 held_ok;

      req_valid = '0; req_value = '0; stray_v = 1'b0; stray_val = '0; stub_en = 1'b1;

      // Reset with every requester asserting: outputs must all read 0.
      req_valid = '1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst ready",      64'(bus.REQ_READY),      64'd0);
      check("rst rsp_valid",  64'(bus.RSP_VALID),      64'd0);
      check("rst rsp_value",  64'(bus.RSP_VALUE),      64'd0);
      check("rst rsp_err",    64'(bus.RSP_ERR),        64'd0);
      check("rst unit_valid", 64'(bus.UNIT_VALID_OUT), 64'd0);
      check("rst unit_value", 64'(bus.UNIT_VALUE_OUT), 64'd0);
      req_valid = '0;
      rst = 1'b0;

      // Directed vectors; owners follow from the round-robin pointer history.
      vecs[0] = '{4'b0001, {8'h00, 8'h00, 8'h00, 8'h1C}, 0, 8'h1C, 3};
      vecs[1] = '{4'b0100, {8'h00, 8'hE4, 8'h00, 8'h00}, 2, 8'h1C, 4};
      vecs[2] = '{4'b1111, {8'h80, 8'h11, 8'h22, 8'h33}, 3, 8'h80, 4};
      vecs[3] = '{4'b0011, {8'h00, 8'h00, 8'h44, 8'h00}, 0, 8'h00, 3};
      vecs[4] = '{4'b0101, {8'h00, 8'h7F, 8'h00, 8'h55}, 2, 8'h7F, 3};
      vecs[5] = '{4'b0001, {8'h00, 8'h00, 8'h00, 8'hFF}, 0, 8'h01, 4};
      vecs[6] = '{4'b1001, {8'h81, 8'h00, 8'h00, 8'h12}, 3, 8'h7F, 4};
      for (int i = 0; i < 7; i++) begin
         do_op($sformatf("vec%0d", i), vecs[i].valid, vecs[i].values,
               vecs[i].owner, vecs[i].result, vecs[i].lat, 1'b0, 1'b0);
      end

      // All four held continuously: grants 0,1,2,3,0.
      do_reset();
      for (int g = 0; g < 5; g++) begin
         do_op($sformatf("rr%0d", g), 4'b1111, {8'h40, 8'h30, 8'h20, 8'h10},
               g % NUM_REQ, 8'h10 + 8'(16 * (g % NUM_REQ)), 3, (g < 4), 1'b0);
      end

      // Stray unit result in IDLE: nothing happens.
      @(posedge clk); #1;
      stray_v = 1'b1; stray_val = 8'h77;
      @(posedge clk); #1;
      stray_v = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("stray idle rsp_valid",  64'(bus.RSP_VALID),      64'd0);
         check("stray idle unit_valid", 64'(bus.UNIT_VALID_OUT), 64'd0);
      end
      // Stray during ISSUE is dropped; the real result follows on time.
      do_op("stray_issue", 4'b0100, {8'h00, 8'h9C, 8'h00, 8'h00}, 2, 8'h64, 4, 1'b0, 1'b1);

      // Reset asserted mid-WAIT.
      @(posedge clk); #1;
      req_valid = 4'b0010;
      req_value = {8'h00, 8'h00, 8'hF0, 8'h00};
      wait_grant("rst_wait", 1);
      @(posedge clk); #1;   // ISSUE
      @(posedge clk); #1;   // WAIT
      req_valid = 4'b0011;
      rst = 1'b1;
      #1;
      check("midrst ready",      64'(bus.REQ_READY),      64'd0);
      check("midrst rsp_valid",  64'(bus.RSP_VALID),      64'd0);
      check("midrst rsp_value",  64'(bus.RSP_VALUE),      64'd0);
      check("midrst rsp_err",    64'(bus.RSP_ERR),        64'd0);
      check("midrst unit_valid", 64'(bus.UNIT_VALID_OUT), 64'd0);
      check("midrst unit_value", 64'(bus.UNIT_VALUE_OUT), 64'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      req_valid = '0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("aborted no rsp", 64'(bus.RSP_VALID), 64'd0);
      end
      do_op("post_rst", 4'b0011, {8'h00, 8'h00, 8'h21, 8'h12}, 0, 8'h12, 3, 1'b0, 1'b0);

      // Unit never answers.
      stub_en = 1'b0;
      @(posedge clk); #1;
      req_valid = 4'b0001;
      req_value = {8'h00, 8'h00, 8'h00, 8'h05};
      wait_grant("noans", 0);
      @(posedge clk); #1;
      req_valid = '0;
`ifdef ABS_ARB_TIMEOUT_EN
      // Accept at t, issue at t+1, error response at issue+9.
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         check("tmo rsp_valid", 64'(bus.RSP_VALID), (k == 10) ? 64'd1 : 64'd0);
      end
      check("tmo rsp_err",   64'(bus.RSP_ERR),   64'd1);
      check("tmo rsp_value", 64'(bus.RSP_VALUE), 64'd0);
      stub_en = 1'b1;
      do_op("after_tmo", 4'b0010, {8'h00, 8'h00, 8'h0A, 8'h00}, 1, 8'h0A, 3, 1'b0, 1'b0);
`else
      // Without the timeout WAIT holds indefinitely.
      held_ok = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.RSP_VALID != '0 || bus.REQ_READY != '0) held_ok = 1'b0;
      end
      check("wait held", 64'(held_ok), 64'd1);
      stub_en = 1'b1;
      do_reset();
      do_op("after_hold", 4'b0010, {8'h00, 8'h00, 8'h0A, 8'h00}, 1, 8'h0A, 3, 1'b0, 1'b0);
`endif

      // Randomized phase against a cycle-level model.
      do_reset();
      m_busy = 1'b0; m_ptr = NUM_REQ - 1; m_owner = 0; m_acc = -10; m_rsp = -10;
      m_op = '0; m_res = '0;
      for (int c = 0; c < 600; c++) begin
         @(posedge clk); #1;
         req_valid = NUM_REQ'($urandom) & NUM_REQ'($urandom);
         for (int i = 0; i < NUM_REQ; i++) req_value[i*WIDTH +: WIDTH] = WIDTH'($urandom);
         @(negedge clk);
         exp_ready = m_busy ? '0 : rr_pick(req_valid, m_ptr);
         check("rnd ready", 64'(bus.REQ_READY), 64'(exp_ready));
         check("rnd unit_valid", 64'(bus.UNIT_VALID_OUT), 64'(m_busy && c == m_acc + 1));
         if (m_busy && c == m_acc + 1)
            check("rnd unit_value", 64'(bus.UNIT_VALUE_OUT), 64'(m_op));
         check("rnd rsp_valid", 64'(bus.RSP_VALID),
               (m_busy && c == m_rsp) ? 64'(NUM_REQ'(1) << m_owner) : 64'd0);
         if (m_busy && c == m_rsp) begin
            check("rnd rsp_value", 64'(bus.RSP_VALUE), 64'(m_res));
            check("rnd rsp_err",   64'(bus.RSP_ERR),   64'd0);
            m_busy = 1'b0;
         end else if (!m_busy && exp_ready != '0) begin
            for (int i = 0; i < NUM_REQ; i++) if (exp_ready[i]) m_owner = i;
            m_busy = 1'b1;
            m_acc  = c;
            m_ptr  = m_owner;
            m_op   = req_value[m_owner*WIDTH +: WIDTH];
            m_res  = abs_of(m_op);
            m_rsp  = c + (m_op[WIDTH-1] ? 4 : 3);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fixed_point_abs_arbiter.md
Name: fixed_point_abs_arbiter

Overview:
Shares one fixed-point absolute-value unit between NUM_REQ requesters. Requesters are arbitered round-robin, and exactly one operation is in flight at a time. The block captures the unit's result and returns it to the owning requester as a one-cycle response pulse. It sits between neuron/layer datapath clients and the single shared ABS instance.

Parameters:
WIDTH, 8, data width of operands/results (fixed-point, passed through unmodified)
NUM_REQ, 4, number of requesters (>=2)
TIMEOUT_CYCLES, 8, WAIT-state cycles before abort (used only with timeout feature)

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-high
REQ_VALID  in  NUM_REQ  per-requester request valid
REQ_VALUE  in  NUM_REQ*WIDTH  operands; requester i at [i*WIDTH +: WIDTH]
REQ_READY  out  NUM_REQ  one-hot grant/accept
RSP_VALID  out  NUM_REQ  one-hot response pulse to owning requester
RSP_VALUE  out  WIDTH  result, valid when any RSP_VALID bit is set
RSP_ERR  out  1  response is an aborted op (timeout feature only)
UNIT_VALUE_OUT  out  WIDTH  operand to shared unit
UNIT_VALID_OUT  out  1  operand valid to shared unit
UNIT_VALUE_IN  in  WIDTH  result from shared unit
UNIT_VALID_IN  in  1  result valid from shared unit

Behaviour:
- One clock domain; reset is asynchronous and active-high.
- Reset values: REQ_READY=0, RSP_VALID=0, RSP_VALUE=0, RSP_ERR=0, UNIT_VALID_OUT=0, UNIT_VALUE_OUT=0, state=IDLE, rr pointer=NUM_REQ-1 (requester 0 wins first).
- FSM has states IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - REQ_READY is combinational and one-hot: the first requester with REQ_VALID set, searching from pointer+1 with wrap.
  - A transfer occurs on REQ_VALID&REQ_READY. On transfer: latch operand and owner id, set pointer=owner, go to ISSUE.
  - REQ_READY is 0 in every other state.
- ISSUE: UNIT_VALID_OUT=1 for exactly one cycle, UNIT_VALUE_OUT=latched operand. Go to WAIT.
- WAIT:
  - On UNIT_VALID_IN, capture UNIT_VALUE_IN and go to RESP.
  - UNIT_VALID_IN in any other state is ignored and dropped.
- RESP: RSP_VALID[owner]=1 for one cycle with RSP_VALUE=captured result. Go to IDLE. There is no response backpressure.
- Latency, with the unit's latency L: accept at cycle t -> UNIT_VALID_OUT at t+1 -> RSP_VALID at t+2+L.
  - Unit latency is 1 for non-negative operands and 2 for negative operands, giving response at t+3 and t+4 respectively.
- Throughput: one op per L+3 cycles.
- Fairness: a requester holding REQ_VALID is granted within NUM_REQ-1 other grants.
- Simultaneous requests: only one is accepted per IDLE visit. Losers keep REQ_VALID asserted; they are not required to hold their value stable until granted.
- REQ_VALID dropped before grant: no transfer, no state effect.
- Data:
  - The result is passed through bit-exact.
  - The most-negative operand (-2^(WIDTH-1)) result is whatever the unit returns; no saturation here.
- Reset mid-operation: returns to IDLE immediately and loses the in-flight op with no response. RST must also reset the shared unit, so no stale result arrives.
- RSP_VALUE holds its last value between pulses.

Optional Feature:
- Macro ABS_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT.
  - If no UNIT_VALID_IN arrives after TIMEOUT_CYCLES cycles, go to RESP with RSP_VALUE=0 and RSP_ERR=1 for the same single cycle as RSP_VALID.
  - A late result is dropped unless it lands in a later WAIT. Integration must make this impossible by choosing TIMEOUT_CYCLES greater than the unit's latency.
- Undefined: no counter is present, RSP_ERR is tied 0, and WAIT is held indefinitely.

Decomposition:
- Package abs_arb_pkg:
  - state enum typedef (IDLE/ISSUE/WAIT/RESP)
  - function computing id width as $clog2(NUM_REQ)
  - timeout counter width constant
- Sub-module rr_arbiter: request vector plus pointer in, one-hot grant and encoded id out. Combinational; the pointer is held in the parent.

Test Plan:
- Reset then req0 only, value 0x1C (3.5 at FRAC_BITS=3) -> REQ_READY[0] at accept cycle t, UNIT_VALID_OUT at t+1, RSP_VALID=4'b0001 with 0x1C at t+3.
- req2 only, value 0xE4 (-3.5) -> RSP_VALID=4'b0100 with 0x1C at t+4.
- All four requesters held valid continuously -> grant order 0,1,2,3,0; each response pulse routed to the matching bit; no REQ_READY while busy.
- Stray UNIT_VALID_IN injected in IDLE and in ISSUE -> no RSP_VALID, state unaffected.
- RST asserted during WAIT -> all outputs 0 asynchronously. After release, next grant goes to requester 0 and no response appears for the aborted op.
- With ABS_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, unit stub never answers -> RSP_VALID with RSP_ERR=1 and RSP_VALUE=0 at issue+9; the next request completes normally.
